// File: rtl/pipe_pkg.sv
// Shared types and constants for the request-encoder slice.
// Index width and request count are tied together: IDXW = $clog2(NREQ).
package pipe_pkg;

    localparam int NREQ = 32;
    localparam int IDXW = 5;

    typedef logic [IDXW-1:0] reg_idx_t;

    typedef enum logic {
        ENC_IDLE,
        ENC_PRESENT
    } enc_state_t;

    // One-hot decode of an index; the inverse of what the encoder produces.
    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc32_5.sv
// Combinational rotating priority encoder, 32 lines to a 5-bit index.
// The lowest set bit at or above 'start' wins, wrapping past 31 back to 0.
// With start tied to 0 it degenerates into a plain lowest-index-wins encoder.
module prio_enc32_5
    import pipe_pkg::*;
(
    input  logic [31:0] vec,
    input  logic [4:0]  start,
    output logic [4:0]  idx,
    output logic        any
);

    // Concatenating the vector with itself makes the rotate a plain slice.
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDXW-1:0]   w_off;

    assign w_dbl = {vec, vec};
    assign w_rot = w_dbl[start +: NREQ];

    // Find the lowest set bit of the rotated vector (downward scan, last hit wins).
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDXW'(i);
            end
        end
    end

    // Undo the rotation; the 5-bit add wraps modulo 32 naturally.
    assign idx = w_off + start;
    assign any = |vec;

endmodule

// File: rtl/req_enc32_5.sv
// Sequential 32->5 request encoder.
// Request pulses accumulate in a pending vector; one pending index at a time
// is offered on a valid/ready handshake and its bit is cleared on acceptance.
// A grant takes two cycles (IDLE pick, PRESENT handshake) by design, so the
// selection always works from the registered pending vector.
module req_enc32_5
    import pipe_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_set,
    output logic [4:0]  idx_out,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] pend_out
);

    enc_state_t      r_state;
    logic [NREQ-1:0] r_pend;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] r_idx;
    logic            r_valid;

    enc_state_t      w_state_nxt;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [IDXW-1:0] w_idx_nxt;
    logic            w_valid_nxt;

    logic            w_accept;
    logic [NREQ-1:0] w_clr;
    logic [NREQ-1:0] w_pend_nxt;
    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_sel;
    logic            w_any;

    // A handshake only counts while an index is actually being offered.
    assign w_accept = r_valid & ready;
    assign w_clr    = w_accept ? idx_onehot(r_idx) : '0;

    // New requests are OR'd in after the clear, so a same-cycle set survives.
    assign w_pend_nxt = (r_pend & ~w_clr) | req_set;

    // Fixed-priority mode always scans from line 0.
    assign w_start = (ROUND_ROBIN != 0) ? r_ptr : '0;

    prio_enc32_5 u_prio (
        .vec   (r_pend),
        .start (w_start),
        .idx   (w_sel),
        .any   (w_any)
    );

    // Next-state and next-output decode for the IDLE/PRESENT handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ENC_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_sel;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ENC_PRESENT;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            ENC_PRESENT: begin
                // idx_out is frozen here; new requests only land in pend.
                if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ENC_IDLE;
                    if (ROUND_ROBIN != 0) begin
                        w_ptr_nxt = r_idx + 5'd1;
                    end
                end
            end
        endcase
    end

    // State, pending vector and presented index; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ENC_IDLE;
            r_pend  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign idx_out  = r_idx;
    assign valid    = r_valid;
    assign pend_out = r_pend;

endmodule
